// File: rtl/seq_divider.sv
// Radix-2 restoring sequential unsigned divider, one quotient bit per cycle.
// Optional round-half-up stage enabled with `define SEQ_DIVIDER_ROUND_EN.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_ROUND_EN
    localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01
`ifdef SEQ_DIVIDER_ROUND_EN
        , S_ROUND = 2'b10
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic             dz_s;

    // Trial subtraction is one bit wider than the operands so bit WIDTH is the borrow.
    assign rem_shift_s = {rem_q, shift_q[WIDTH-1]};
    assign trial_s     = rem_shift_s - {1'b0, divisor_q};
    assign borrow_s    = trial_s[WIDTH];
    assign rem_step_s  = borrow_s ? rem_shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    assign q_step_s    = {shift_q[WIDTH-2:0], ~borrow_s};
    assign dz_s        = (divisor_q == {WIDTH{1'b0}});

`ifdef SEQ_DIVIDER_ROUND_EN
    logic             round_up_s;
    logic [WIDTH-1:0] q_inc_s;

    assign round_up_s = ({rem_q, 1'b0} >= {1'b0, divisor_q});
    assign q_inc_s    = (&shift_q) ? shift_q : (shift_q + Q_ONE);
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        dividend_d  = dividend_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    shift_d    = dividend;
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    rem_d      = {WIDTH{1'b0}};
                    cnt_d      = {CW{1'b0}};
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    dbz_d      = 1'b0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_RUN: begin
                shift_d = q_step_s;
                rem_d   = rem_step_s;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
`ifdef SEQ_DIVIDER_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    ready_d     = 1'b1;
                    dbz_d       = dz_s;
                    quotient_d  = dz_s ? {WIDTH{1'b1}} : q_step_s;
                    remainder_d = dz_s ? dividend_q : rem_step_s;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
`ifdef SEQ_DIVIDER_ROUND_EN
            S_ROUND: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                dbz_d   = dz_s;
                if (dz_s) begin
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dividend_q;
                end else if (round_up_s) begin
                    quotient_d  = q_inc_s;
                    remainder_d = rem_q - divisor_q;
                end else begin
                    quotient_d  = shift_q;
                    remainder_d = rem_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            divisor_q   <= {WIDTH{1'b0}};
            dividend_q  <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            dividend_q  <= dividend_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign div_by_zero = dbz_q;

endmodule
